conv_mac_sequencer: RTL and testbench

//  Sequences one shared 8x8 signed shift-multiplier (MULTB_shift: registered A*B>>>8, 15-bit result, done 1 cycle after start) over a TAPS-long convolution window.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_mac_sequencer_mult.sv | 34 +++
 rtl/conv_mac_sequencer.sv | 128 ++++++++++++
 tb/tb_conv_mac_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and output saturation
// for the convolution MAC sequencer.
package conv_pkg;

  localparam int TAPS = 9;
  localparam int DW   = 8;
  localparam int PW   = 15;
  localparam int AW   = 16;

  localparam int SAT_MAX = (2 ** (DW - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (DW - 1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_t;

  // Clamp a widened sum into the signed output range.
  function automatic logic signed [DW-1:0] saturate(
    input logic signed [AW:0] v
  );
    logic signed [AW:0] hi;
    logic signed [AW:0] lo;
    hi = (AW + 1)'(SAT_MAX);
    lo = (AW + 1)'(SAT_MIN);
    if (v > hi) begin
      return DW'(SAT_MAX);
    end else if (v < lo) begin
      return DW'(SAT_MIN);
    end else begin
      return v[DW-1:0];
    end
  endfunction

endpackage

// File: rtl/conv_mac_sequencer_mult.sv
// Shared signed shift-multiplier: registered (A*B)>>>8,
// done follows start by one cycle.
module MULTB_shift
  import conv_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [DW-1:0] A,
  input  logic signed [DW-1:0] B,
  output logic                 done,
  output logic signed [PW-1:0] result
);

  logic signed [2*DW-1:0] w_prod;
  logic signed [2*DW-1:0] w_shift;

  assign w_prod  = A * B;
  assign w_shift = w_prod >>> 8;

  // Register the floored product; done marks a fresh result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= start;
      if (start) begin
        result <= PW'(w_shift);
      end
    end
  end

endmodule

// File: rtl/conv_mac_sequencer.sv
// Streams TAPS pixel/weight pairs through one multiplier,
// accumulates, adds bias, optional ReLU, saturates.
module conv_mac_sequencer #(
  parameter int TAPS = conv_pkg::TAPS,
  parameter int DW   = conv_pkg::DW,
  parameter int PW   = conv_pkg::PW,
  parameter int AW   = conv_pkg::AW
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        relu_en,
  input  logic signed [DW-1:0]        bias,
  output logic                        busy,
  output logic                        rd_en,
  output logic [$clog2(TAPS)-1:0]     tap_addr,
  input  logic signed [DW-1:0]        pix_i,
  input  logic signed [DW-1:0]        wgt_i,
  output logic                        out_valid,
  output logic signed [DW-1:0]        out_data
);

  import conv_pkg::*;

  localparam int TW = $clog2(TAPS);

  state_t               r_state;
  logic [1:0]           r_drain;
  logic signed [DW-1:0] r_bias;
  logic                 r_relu;
  logic                 r_mul_start;
  logic signed [AW-1:0] r_acc;

  logic                 w_done;
  logic signed [PW-1:0] w_result;
  logic                 w_accept;
  logic signed [AW:0]   w_sum;
  logic signed [AW:0]   w_relu;

  assign w_accept = start &&
                    ((r_state == S_IDLE) || (r_state == S_OUT));

  assign w_sum  = (AW + 1)'(r_acc) + (AW + 1)'(r_bias);
  assign w_relu = (r_relu && (w_sum < 0)) ? '0 : w_sum;

  MULTB_shift u_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (r_mul_start),
    .A      (pix_i),
    .B      (wgt_i),
    .done   (w_done),
    .result (w_result)
  );

  // Window control: read issue, drain wait, output pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_drain   <= '0;
      r_bias    <= '0;
      r_relu    <= 1'b0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      tap_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE, S_OUT: begin
          if (start) begin
            r_bias   <= bias;
            r_relu   <= relu_en;
            busy     <= 1'b1;
            rd_en    <= 1'b1;
            tap_addr <= '0;
            r_state  <= S_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (tap_addr == TW'(TAPS - 1)) begin
            rd_en    <= 1'b0;
            tap_addr <= '0;
            r_drain  <= '0;
            r_state  <= S_DRAIN;
          end else begin
            tap_addr <= tap_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain == 2'd2) begin
            out_valid <= 1'b1;
            out_data  <= saturate(w_relu);
            r_state   <= S_OUT;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage 1: multiplier start follows the read strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_start <= 1'b0;
    end else begin
      r_mul_start <= rd_en;
    end
  end

  // Stage 2: clear on accept, add each finished product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_done) begin
      r_acc <= r_acc + AW'(w_result);
    end
  end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Bench for conv_mac_sequencer: directed vectors,
// multi-cycle corner cases and random windows.
`timescale 1ns/1ps
module tb_conv_mac_sequencer;

  localparam int TAPS = 9;

  logic              clk;
  logic              reset;
  logic              start;
  logic              relu_en;
  logic signed [7:0] bias;
  logic              busy;
  logic              rd_en;
  logic [3:0]        tap_addr;
  logic signed [7:0] pix_i;
  logic signed [7:0] wgt_i;
  logic              out_valid;
  logic signed [7:0] out_data;

  conv_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .relu_en   (relu_en),
    .bias      (bias),
    .busy      (busy),
    .rd_en     (rd_en),
    .tap_addr  (tap_addr),
    .pix_i     (pix_i),
    .wgt_i     (wgt_i),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0] pix_mem [TAPS];
  logic signed [7:0] wgt_mem [TAPS];

  // Window buffers: one-cycle read latency, junk otherwise.
  always @(posedge clk) begin
    if (rd_en && tap_addr < TAPS) begin
      pix_i <= pix_mem[tap_addr];
      wgt_i <= wgt_mem[tap_addr];
    end else begin
      pix_i <= 8'($urandom);
      wgt_i <= 8'($urandom);
    end
  end

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int rd_seen = 0;
  int ord_err = 0;
  int ov_cnt = 0;
  int stab_err = 0;
  int last_data = 0;

  // Per-cycle observation of reads, pulses and output hold.
  always @(negedge clk) begin
    if (reset) begin
      last_data = 0;
    end else begin
      if (rd_en) begin
        if (int'(tap_addr) != rd_seen) ord_err++;
        rd_seen++;
        rd_cnt++;
      end
      if (out_valid) begin
        ov_cnt++;
        last_data = int'(out_data);
      end else if (int'(out_data) != last_data) begin
        stab_err++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill(input int p, input int w);
    for (int k = 0; k < TAPS; k++) begin
      pix_mem[k] = 8'(p);
      wgt_mem[k] = 8'(w);
    end
  endtask

  function automatic int model(input int b, input bit relu);
    int s;
    s = 0;
    for (int k = 0; k < TAPS; k++) begin
      int p;
      int w;
      p = pix_mem[k];
      w = wgt_mem[k];
      s += (p * w) >>> 8;
    end
    s += b;
    if (relu && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic clr_counts();
    rd_cnt  = 0;
    rd_seen = 0;
    ord_err = 0;
    ov_cnt  = 0;
  endtask

  // One window; mask bit n drives start for edge En.
  task automatic run_window(input string name, input int b,
                            input bit relu, input int mask,
                            input int exp);
    int n;
    int lat;
    int got;
    n   = 0;
    lat = -1;
    got = 999;
    @(negedge clk);
    clr_counts();
    start   = 1'b1;
    bias    = 8'(b);
    relu_en = relu;
    @(posedge clk);
    #1;
    start = ((mask >> 1) & 1) != 0;
    while (n < 40 && lat < 0) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) begin
        lat = n;
        got = int'(out_data);
      end
      start = ((mask >> (n + 1)) & 1) != 0;
    end
    start = 1'b0;
    chk({name, " latency"}, lat, 12);
    chk({name, " data"}, got, exp);
    @(posedge clk);
    #1;
    chk({name, " valid width"}, int'(out_valid), 0);
    chk({name, " busy low"}, int'(busy), 0);
    repeat (3) @(negedge clk);
    chk({name, " pulses"}, ov_cnt, 1);
    chk({name, " reads"}, rd_cnt, TAPS);
    chk({name, " tap order"}, ord_err, 0);
  endtask

  typedef struct {
    int    pix;
    int    wgt;
    int    b;
    bit    relu;
    int    exp;
    string name;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{32, 64, 0, 1'b0, 72, "c1 sum72"};
    vecs[1] = '{64, 64, 0, 1'b0, 127, "c2 satpos"};
    vecs[2] = '{64, 64, -20, 1'b0, 124, "c2 bias"};
    vecs[3] = '{-64, 64, 0, 1'b0, -128, "c3 satneg"};
    vecs[4] = '{-64, 64, 0, 1'b1, 0, "c3 relu"};
    vecs[5] = '{3, -1, 0, 1'b0, -9, "c4 floor"};

    reset   = 1'b1;
    start   = 1'b0;
    relu_en = 1'b0;
    bias    = '0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst rd_en", int'(rd_en), 0);
    chk("rst tap_addr", int'(tap_addr), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fill(vecs[i].pix, vecs[i].wgt);
      run_window(vecs[i].name, vecs[i].b, vecs[i].relu, 0,
                 vecs[i].exp);
    end

    fill(32, 64);
    run_window("c5 ignore", 0, 1'b0, (1 << 3) | (1 << 7), 72);

    @(negedge clk);
    clr_counts();
    fill(64, 64);
    start = 1'b1;
    bias  = '0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("c6 rst busy", int'(busy), 0);
    chk("c6 rst rd_en", int'(rd_en), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("c6 no pulse", ov_cnt, 0);
    fill(32, 64);
    run_window("c6 after", 0, 1'b0, 0, 72);

    @(negedge clk);
    clr_counts();
    start = 1'b1;
    repeat (30) @(negedge clk);
    chk("held start pulses", ov_cnt, 2);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("held start data", int'(out_data), 72);

    for (int r = 0; r < 15; r++) begin
      int b;
      bit rl;
      for (int k = 0; k < TAPS; k++) begin
        pix_mem[k] = 8'($urandom);
        wgt_mem[k] = 8'($urandom);
      end
      b  = $urandom_range(0, 255) - 128;
      rl = 1'($urandom);
      run_window($sformatf("rand%0d", r), b, rl, 0, model(b, rl));
    end

    chk("out hold", stab_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
